// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter for the Gumnut core. It holds the PC, a return-address
// stack (jsb/ret/int/reti) and a nested interrupt flag-save stack (Z, C).
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   cen, pc_en        global clock enable, PC/stack update enable (both needed)
//   pc_op             0 INC, 1 JMP, 2 BZ, 3 BNZ, 4 BC, 5 BNC, 6-7 hold
//   z_i, c_i          ALU flags used for branch conditions and interrupt save
//   addr_i, disp_i    absolute jump target, signed branch displacement
//   push_i, pop_i     jsb / ret
//   int_i, reti_i     interrupt entry / return
//   pc_o              registered program counter
//   intz_o, intc_o    top of flag-save stack (0 when empty)
//   depth_o, full_o, empty_o   return-stack occupancy and status
//   ovf_o, unf_o      sticky overflow / underflow of either stack, cleared by rst only
module pc_stack_unit #(
    parameter int ADDR_W      = 12,
    parameter int DISP_W      = 8,
    parameter int STACK_DEPTH = 8,
    parameter int INT_DEPTH   = 1,
    parameter int RESET_PC    = 0,
    parameter int INT_VECTOR  = 1,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              pc_en,
    input  logic [2:0]        pc_op,
    input  logic              z_i,
    input  logic              c_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DISP_W-1:0] disp_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              int_i,
    input  logic              reti_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              intz_o,
    output logic              intc_o,
    output logic [DW-1:0]     depth_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              ovf_o,
    output logic              unf_o
);
    // Index widths; storage is rounded up to a power of two so any index value is in range.
    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int FDW = $clog2(INT_DEPTH + 1);
    localparam int FAW = (INT_DEPTH > 1) ? $clog2(INT_DEPTH) : 1;

    localparam logic [2:0] OP_INC = 3'd0, OP_JMP = 3'd1, OP_BZ = 3'd2,
                           OP_BNZ = 3'd3, OP_BC = 3'd4, OP_BNC = 3'd5;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rs [0:(1<<AW)-1];
    logic [DW-1:0]     sp;
    logic [1:0]        fs [0:(1<<FAW)-1];
    logic [FDW-1:0]    fsp;
    logic              ovf, unf;

    logic [ADDR_W-1:0] pc_inc, pc_br, pc_opnext;
    logic [DW-1:0]     sp_m1;
    logic [FDW-1:0]    fsp_m1;
    logic [AW-1:0]     wr_idx, top_idx;
    logic [FAW-1:0]    fwr_idx, ftop_idx;
    logic              rs_full, rs_empty, fs_full, fs_empty;

    always_comb begin
        pc_inc   = pc + ADDR_W'(1);
        // Sized cast of a signed value sign-extends the displacement.
        pc_br    = pc + ADDR_W'($signed(disp_i));
        sp_m1    = sp - DW'(1);
        fsp_m1   = fsp - FDW'(1);
        wr_idx   = sp[AW-1:0];
        top_idx  = sp_m1[AW-1:0];
        fwr_idx  = fsp[FAW-1:0];
        ftop_idx = fsp_m1[FAW-1:0];
        rs_full  = (sp == DW'(STACK_DEPTH));
        rs_empty = (sp == '0);
        fs_full  = (fsp == FDW'(INT_DEPTH));
        fs_empty = (fsp == '0);

        pc_opnext = pc;
        case (pc_op)
            OP_INC: pc_opnext = pc_inc;
            OP_JMP: pc_opnext = addr_i;
            OP_BZ:  pc_opnext = z_i  ? pc_br : pc_inc;
            OP_BNZ: pc_opnext = !z_i ? pc_br : pc_inc;
            OP_BC:  pc_opnext = c_i  ? pc_br : pc_inc;
            OP_BNC: pc_opnext = !c_i ? pc_br : pc_inc;
            default: pc_opnext = pc;   // reserved ops hold
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= ADDR_W'(RESET_PC);
            sp  <= '0;
            fsp <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (cen && pc_en) begin
            if (int_i) begin
                // Return address is the current, unincremented PC.
                if (rs_full) ovf <= 1'b1;
                else begin
                    rs[wr_idx] <= pc;
                    sp         <= sp + DW'(1);
                end
                if (fs_full) ovf <= 1'b1;
                else begin
                    fs[fwr_idx] <= {z_i, c_i};
                    fsp         <= fsp + FDW'(1);
                end
                pc <= ADDR_W'(INT_VECTOR);
            end else if (reti_i || pop_i) begin
                if (rs_empty) begin
                    pc  <= ADDR_W'(RESET_PC);
                    unf <= 1'b1;
                end else begin
                    pc <= rs[top_idx];
                    sp <= sp_m1;
                end
                if (reti_i) begin
                    if (fs_empty) unf <= 1'b1;
                    else          fsp <= fsp_m1;
                end
            end else if (push_i) begin
                if (rs_full) ovf <= 1'b1;
                else begin
                    rs[wr_idx] <= pc_inc;
                    sp         <= sp + DW'(1);
                end
                pc <= pc_opnext;
            end else begin
                pc <= pc_opnext;
            end
        end
    end

    assign pc_o    = pc;
    assign depth_o = sp;
    assign full_o  = rs_full;
    assign empty_o = rs_empty;
    assign ovf_o   = ovf;
    assign unf_o   = unf;
    assign intz_o  = fs_empty ? 1'b0 : fs[ftop_idx][1];
    assign intc_o  = fs_empty ? 1'b0 : fs[ftop_idx][0];
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (ADDR_W=12, DISP_W=8, STACK_DEPTH=8, INT_DEPTH=2,
// RESET_PC=0, INT_VECTOR=1). Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point after the next edge.
module tb_pc_stack_unit;
    logic        clk = 1'b0;
    logic        rst, cen, pc_en, z_i, c_i, push_i, pop_i, int_i, reti_i;
    logic [2:0]  pc_op;
    logic [11:0] addr_i, pc_o;
    logic [7:0]  disp_i;
    logic        intz_o, intc_o, full_o, empty_o, ovf_o, unf_o;
    logic [3:0]  depth_o;

    int n_vec = 0;
    int n_bad = 0;

    pc_stack_unit #(
        .ADDR_W(12), .DISP_W(8), .STACK_DEPTH(8), .INT_DEPTH(2),
        .RESET_PC(0), .INT_VECTOR(1)
    ) dut (
        .clk(clk), .rst(rst), .cen(cen), .pc_en(pc_en), .pc_op(pc_op),
        .z_i(z_i), .c_i(c_i), .addr_i(addr_i), .disp_i(disp_i),
        .push_i(push_i), .pop_i(pop_i), .int_i(int_i), .reti_i(reti_i),
        .pc_o(pc_o), .intz_o(intz_o), .intc_o(intc_o), .depth_o(depth_o),
        .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o), .unf_o(unf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled cycle: {int, reti, pop, push}, pc_op, addr, disp, z, c.
    task automatic act(input logic [3:0] ctl, input logic [2:0] op, input logic [11:0] a,
                       input logic [7:0] d, input logic z, input logic c);
        {int_i, reti_i, pop_i, push_i} = ctl;
        pc_op = op; addr_i = a; disp_i = d; z_i = z; c_i = c;
        tick();
        {int_i, reti_i, pop_i, push_i} = 4'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    localparam logic [3:0] NONE = 4'b0000, PUSH = 4'b0001, POP = 4'b0010,
                           RETI = 4'b0100, INT = 4'b1000;

    initial begin
        rst = 1'b1; cen = 1'b1; pc_en = 1'b1; pc_op = 3'd0; z_i = 1'b0; c_i = 1'b0;
        addr_i = '0; disp_i = '0; push_i = 1'b0; pop_i = 1'b0; int_i = 1'b0; reti_i = 1'b0;

        // Reset state
        do_rst();
        chk("rst_pc", pc_o, 0);
        chk("rst_depth", depth_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_unf", unf_o, 0);
        chk("rst_intz", intz_o, 0);
        chk("rst_intc", intc_o, 0);

        // INC x5, then enables low
        for (int i = 0; i < 5; i++) act(NONE, 3'd0, 12'h0, 8'h0, 0, 0);
        chk("inc5", pc_o, 5);
        cen = 1'b0;
        act(NONE, 3'd0, 12'h0, 8'h0, 0, 0);
        act(NONE, 3'd1, 12'h123, 8'h0, 0, 0);
        chk("cen_hold", pc_o, 5);
        cen = 1'b1; pc_en = 1'b0;
        act(PUSH, 3'd0, 12'h0, 8'h0, 0, 0);
        chk("pcen_hold", pc_o, 5);
        chk("pcen_hold_depth", depth_o, 0);
        pc_en = 1'b1;

        // Branches and wrap
        act(NONE, 3'd1, 12'h010, 8'h00, 0, 0);
        chk("jmp", pc_o, 12'h010);
        act(NONE, 3'd2, 12'h0, 8'hFE, 1, 0);
        chk("bz_taken", pc_o, 12'h00E);
        act(NONE, 3'd1, 12'h010, 8'h00, 0, 0);
        act(NONE, 3'd2, 12'h0, 8'hFE, 0, 0);
        chk("bz_not", pc_o, 12'h011);
        act(NONE, 3'd3, 12'h0, 8'h05, 0, 0);
        chk("bnz_taken", pc_o, 12'h016);
        act(NONE, 3'd4, 12'h0, 8'h80, 0, 1);
        chk("bc_neg_wrap", pc_o, 12'hF96);
        act(NONE, 3'd5, 12'h0, 8'h80, 0, 1);
        chk("bnc_not", pc_o, 12'hF97);
        act(NONE, 3'd6, 12'h0, 8'h00, 0, 0);
        chk("rsvd_hold", pc_o, 12'hF97);
        act(NONE, 3'd1, 12'hFFF, 8'h00, 0, 0);
        act(NONE, 3'd0, 12'h0, 8'h00, 0, 0);
        chk("inc_wrap", pc_o, 12'h000);
        act(NONE, 3'd1, 12'hFFE, 8'h00, 0, 0);
        act(NONE, 3'd5, 12'h0, 8'h03, 0, 0);
        chk("bnc_fwd_wrap", pc_o, 12'h001);
        chk("no_err_so_far", {ovf_o, unf_o}, 0);

        // Nested jsb x8 from pc=0x001: pushes 0x002, 0x101..0x107
        for (int k = 0; k < 8; k++) begin
            act(PUSH, 3'd1, 12'h100 + 12'(k), 8'h0, 0, 0);
            chk("jsb_pc", pc_o, 12'h100 + 12'(k));
            chk("jsb_depth", depth_o, k + 1);
        end
        chk("full8", full_o, 1);
        chk("ovf_before", ovf_o, 0);
        act(PUSH, 3'd1, 12'h1FF, 8'h0, 0, 0);
        chk("ovf9", ovf_o, 1);
        chk("ovf9_depth", depth_o, 8);
        chk("ovf9_pc", pc_o, 12'h1FF);
        for (int k = 7; k >= 0; k--) begin
            act(POP, 3'd0, 12'h0, 8'h0, 0, 0);
            chk("ret_pc", pc_o, (k == 0) ? 12'h002 : 12'h100 + 12'(k));
            chk("ret_depth", depth_o, k);
        end
        chk("ret_empty", empty_o, 1);
        chk("ret_unf_clear", unf_o, 0);

        // Ret on empty
        act(NONE, 3'd1, 12'h055, 8'h0, 0, 0);
        act(POP, 3'd0, 12'h0, 8'h0, 0, 0);
        chk("unf_pc", pc_o, 0);
        chk("unf_set", unf_o, 1);
        act(NONE, 3'd0, 12'h0, 8'h0, 0, 0);
        act(NONE, 3'd0, 12'h0, 8'h0, 0, 0);
        chk("unf_sticky", unf_o, 1);
        do_rst();
        chk("unf_rst", {ovf_o, unf_o}, 0);

        // Nested interrupts
        act(NONE, 3'd1, 12'h020, 8'h0, 0, 0);
        act(INT, 3'd0, 12'h0, 8'h0, 1, 0);
        chk("int1_pc", pc_o, 1);
        chk("int1_flags", {intz_o, intc_o}, 2'b10);
        chk("int1_depth", depth_o, 1);
        act(NONE, 3'd0, 12'h0, 8'h0, 0, 0);
        act(NONE, 3'd0, 12'h0, 8'h0, 0, 0);
        act(INT, 3'd0, 12'h0, 8'h0, 0, 1);
        chk("int2_pc", pc_o, 1);
        chk("int2_flags", {intz_o, intc_o}, 2'b01);
        act(RETI, 3'd0, 12'h0, 8'h0, 0, 0);
        chk("reti1_pc", pc_o, 3);
        chk("reti1_flags", {intz_o, intc_o}, 2'b10);
        act(RETI, 3'd0, 12'h0, 8'h0, 0, 0);
        chk("reti2_pc", pc_o, 12'h020);
        chk("reti2_flags", {intz_o, intc_o}, 2'b00);
        chk("reti2_status", {depth_o, ovf_o, unf_o}, 0);

        // Flag-stack overflow and underflow
        act(NONE, 3'd1, 12'h040, 8'h0, 0, 0);
        act(INT, 3'd0, 12'h0, 8'h0, 1, 1);
        act(INT, 3'd0, 12'h0, 8'h0, 0, 1);
        chk("fs_ovf_before", ovf_o, 0);
        act(INT, 3'd0, 12'h0, 8'h0, 1, 0);
        chk("fs_ovf", ovf_o, 1);
        chk("fs_ovf_flags", {intz_o, intc_o}, 2'b01);
        chk("fs_ovf_depth", depth_o, 3);
        act(RETI, 3'd0, 12'h0, 8'h0, 0, 0);
        chk("fr1", {pc_o, intz_o, intc_o}, {12'h001, 2'b11});
        act(RETI, 3'd0, 12'h0, 8'h0, 0, 0);
        chk("fr2", {pc_o, intz_o, intc_o}, {12'h001, 2'b00});
        chk("fr2_unf", unf_o, 0);
        act(RETI, 3'd0, 12'h0, 8'h0, 0, 0);
        chk("fr3_pc", pc_o, 12'h040);
        chk("fr3_unf", unf_o, 1);
        chk("fr3_depth", depth_o, 0);

        // Priority: int beats push; pop beats push
        do_rst();
        act(INT | PUSH, 3'd1, 12'h300, 8'h0, 0, 0);
        chk("prio_int_pc", pc_o, 1);
        chk("prio_int_depth", depth_o, 1);
        act(POP | PUSH, 3'd1, 12'h300, 8'h0, 0, 0);
        chk("prio_pop_pc", pc_o, 0);
        chk("prio_pop_depth", depth_o, 0);

        // Reset mid-sequence discards context
        act(PUSH, 3'd1, 12'h222, 8'h0, 0, 0);
        act(INT, 3'd0, 12'h0, 8'h0, 1, 1);
        do_rst();
        chk("midrst", {pc_o, depth_o, intz_o, intc_o, empty_o}, {12'h000, 4'd0, 2'b00, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
